// File: rtl/irq_ctrl_if.sv
// Wishbone register-bus bundle for the interrupt controller.
interface wb_bus_t;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_ms;
    logic [31:0] wb_dat_sm;
    logic        wb_ack;
    logic        wb_err;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_ms,
        input  wb_dat_sm, wb_ack, wb_err
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_ms,
        output wb_dat_sm, wb_ack, wb_err
    );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: sticky pending capture, per-source enable, lowest-index priority, Wishbone regs.
// Optional IRQ_CTRL_SYNC_EN adds a 2-flop synchroniser in front of source capture.
module irq_ctrl #(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] irq_src_i,
    output logic               irq_o,
    output logic [5:0]         irq_id_o,
    wb_bus_t.slave             wb_bus
);

    localparam int unsigned ID_W    = 6;
    localparam int unsigned DAT_W   = 32;
    localparam logic [31:0] ADR_TOP = 32'hC;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_EDGE    = 2'd2;
    localparam logic [1:0] REG_CLAIM   = 2'd3;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] edge_mode;
    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] set_vec;
    logic [NUM_SRC-1:0] clr_vec;
    logic [NUM_SRC-1:0] masked;
    logic [NUM_SRC-1:0] claim_vec;
    logic [NUM_SRC-1:0] wdata;
    logic [NUM_SRC-1:0] wmask;
    logic [DAT_W-1:0]   rdata;
    logic [1:0]         reg_sel;
    logic               req;
    logic               adr_ok;
    logic               wr;
    logic               rd;

    function automatic logic [DAT_W-1:0] lane_mask(input logic [3:0] sel);
        logic [DAT_W-1:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

`ifdef IRQ_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] sync_q1;
    logic [NUM_SRC-1:0] sync_q2;

    // Two-stage synchroniser for asynchronous peripheral lines
    always_ff @(posedge clk) begin
        if (rst_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_src_i;
            sync_q2 <= sync_q1;
        end
    end

    assign src = sync_q2;
`else
    assign src = irq_src_i;
`endif

    assign req     = wb_bus.wb_cyc & wb_bus.wb_stb & ~wb_bus.wb_ack;
    assign adr_ok  = (wb_bus.wb_adr <= ADR_TOP);
    assign reg_sel = wb_bus.wb_adr[3:2];
    assign wr      = req & adr_ok & wb_bus.wb_we;
    assign rd      = req & adr_ok & ~wb_bus.wb_we;
    assign wmask   = NUM_SRC'(lane_mask(wb_bus.wb_sel));
    assign wdata   = NUM_SRC'(wb_bus.wb_dat_ms & lane_mask(wb_bus.wb_sel));

    // Edge-mode sources only capture on a 0->1 transition
    assign set_vec = src & ~(edge_mode & prev);
    assign masked  = pending & enable;
    assign irq_o   = |masked;

    // Lowest index wins: scanning downward leaves the lowest hit last
    always_comb begin
        irq_id_o  = '0;
        claim_vec = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (masked[i]) begin
                irq_id_o     = ID_W'(i + 1);
                claim_vec    = '0;
                claim_vec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        clr_vec = '0;
        if (wr && (reg_sel == REG_PENDING)) begin
            clr_vec = wdata;
        end
        if (rd && (reg_sel == REG_CLAIM)) begin
            clr_vec = claim_vec;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_PENDING: rdata = DAT_W'(pending);
            REG_ENABLE:  rdata = DAT_W'(enable);
            REG_EDGE:    rdata = DAT_W'(edge_mode);
            REG_CLAIM:   rdata = DAT_W'(irq_id_o);
            default:     rdata = '0;
        endcase
    end

    // Set is OR-ed after clear so a concurrent set always wins
    always_ff @(posedge clk) begin
        if (rst_i) begin
            pending          <= '0;
            enable           <= '0;
            edge_mode        <= '0;
            prev             <= '0;
            wb_bus.wb_ack    <= 1'b0;
            wb_bus.wb_err    <= 1'b0;
            wb_bus.wb_dat_sm <= '0;
        end else begin
            prev    <= src;
            pending <= (pending & ~clr_vec) | set_vec;
            if (wr && (reg_sel == REG_ENABLE)) begin
                enable <= (enable & ~wmask) | wdata;
            end
            if (wr && (reg_sel == REG_EDGE)) begin
                edge_mode <= (edge_mode & ~wmask) | wdata;
            end
            wb_bus.wb_ack    <= req;
            wb_bus.wb_err    <= req & ~adr_ok;
            wb_bus.wb_dat_sm <= rd ? rdata : '0;
        end
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller directly downstream of the timer and other peripherals.
- Collects per-source interrupt lines (timer compare = src 0, timer overflow = src 1, others above) into sticky pending bits.
- Masks pending bits per source, prioritises them, and drives a single core interrupt plus the winning source ID.
- Wishbone slave for pending, enable, edge-mode and claim registers.

Parameters:
- NUM_SRC, 8, number of interrupt sources (legal 2..32); unused register bits read 0 and ignore writes.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_i  input  1  synchronous reset, active-high
- irq_src_i  input  NUM_SRC  interrupt request lines, bit n = source n
- irq_o  output  1  core interrupt request, level
- irq_id_o  output  6  highest-priority pending+enabled source ID + 1; 0 = none
- wb_bus  wb_bus_t.slave  -  Wishbone slave (wb_cyc, wb_stb, wb_we, wb_sel[3:0], wb_adr, wb_dat_ms, wb_dat_sm, wb_ack, wb_err)

Behaviour:
- Reset: pending, enable, edge and prev-source registers all 0; irq_o=0, irq_id_o=0, wb_ack=0, wb_err=0, wb_dat_sm=0.
- Register map (word addresses, byte-lane writes honoured via wb_sel):
  - 0x0 PENDING: read; write-1-to-clear.
  - 0x4 ENABLE: RW.
  - 0x8 EDGE: RW; 1 = rising-edge source, 0 = level source.
  - 0xC CLAIM: read-only, returns irq_id_o; writes ignored.
- Any address > 0xC: access completes with wb_ack=1 and wb_err=1, no register effect, wb_dat_sm=0.
- Source capture, per bit n, evaluated each cycle:
  - Level mode: set when irq_src_i[n]=1.
  - Edge mode: set when irq_src_i[n]=1 and prev[n]=0.
  - prev[n] registers irq_src_i[n] every cycle. prev resets to 0, so a source already high when reset releases counts as a rising edge.
- Latency: source asserted before edge k gives pending[n]=1 after edge k. irq_o and irq_id_o are combinational from the pending and enable flops, so they are valid in the same cycle.
- Pending is set regardless of enable. Enabling a source that is already pending raises irq_o in the cycle after the write edge.
- irq_o = |(pending & enable).
- Priority: lowest index wins. irq_id_o = index+1 of the lowest set bit of (pending & enable), else 0.
- Wishbone handshake:
  - Request = wb_cyc & wb_stb & !wb_ack.
  - On the request edge, wb_ack is registered high for exactly one cycle, then low. Back-to-back requests are therefore acked every other cycle.
  - Read data is registered with the ack.
  - Write effects take place on the same edge that raises wb_ack.
  - Dropping wb_cyc/wb_stb before the ack edge aborts the access with no effect.
- CLAIM read: returns current irq_id_o. If nonzero, clears that source's pending bit on the ack edge.
- Clearing a level source (claim or W1C) while its line is still high: set wins, and the bit stays 1.
- Simultaneous set and clear on the same bit in the same cycle: set wins.
- Writing EDGE does not clear pending.
- Reset mid-transaction: all state clears and no ack is issued. The master must restart the access.

Optional Feature:
- Macro IRQ_CTRL_SYNC_EN.
- When defined: each irq_src_i bit passes through a 2-flop synchroniser (reset 0) before capture, adding 2 cycles of latency (pending set after edge k+2). Edge detection operates on the synchronised signal.
- When undefined: sources are used directly, as specified above.

Test Plan:
- Reset, then ENABLE=0x3; pulse irq_src_i[0] high for 1 cycle in level mode -> pending=0x1, irq_o=1, irq_id_o=1. CLAIM read returns 1 and clears pending -> irq_o=0 the next cycle.
- irq_src_i[1] and irq_src_i[0] asserted in the same cycle, ENABLE=0x3 -> irq_id_o=1. Claim -> irq_id_o=2. Claim again -> irq_id_o=0 and CLAIM reads 0.
- EDGE=0x2; hold irq_src_i[1] high for 10 cycles -> pending[1] set once. W1C 0x2 while the line is still high -> stays 0. Line low then high again -> set.
- Level source 2 held high; write PENDING=0x4 -> bit 2 reads 1 on the following read. ENABLE=0 -> irq_o=0 with PENDING=0x4.
- Read at address 0x10 -> wb_ack=1 and wb_err=1 for one cycle, data 0. Write to ENABLE with wb_sel=4'b0001, data 0xFFFFFFFF, NUM_SRC=8 -> ENABLE reads 0xFF.
- With IRQ_CTRL_SYNC_EN: source rises before edge k -> pending observed after edge k+2. Assert rst_i during an in-flight read -> no ack, all registers 0.
